// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use stalls, EX redirects,
// multi-cycle EX ops and debug halt/step into per-register enables and flushes.
module pipeline_ctrl #(
    parameter int MC_LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic hdu_stall,
    input  logic br_taken_ex,
    input  logic mc_start_ex,
    input  logic halt_req,
    input  logic step_req,
    output logic pc_en,
    output logic fd_en,
    output logic fd_flush,
    output logic dx_en,
    output logic dx_flush,
    output logic xm_flush,
    output logic mc_busy,
    output logic halted
);

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_MC_WAIT = 2'd1;
    localparam logic [1:0] S_HALT    = 2'd2;
    localparam logic [1:0] S_STEP    = 2'd3;

    localparam logic [3:0] MC_INIT = 4'(MC_LATENCY - 1);

    typedef struct packed {
        logic pc;
        logic fd;
        logic fd_fl;
        logic dx;
        logic dx_fl;
        logic xm;
    } ctl_t;

    // Flush wins over enable at each register, so enables may stay high under a flush.
    localparam ctl_t CTL_GO     = 6'b110_100;
    localparam ctl_t CTL_BRANCH = 6'b111_110;
    localparam ctl_t CTL_STALL  = 6'b000_110;
    localparam ctl_t CTL_FREEZE = 6'b000_001;
    localparam ctl_t CTL_RESET  = 6'b001_011;

    logic [1:0] state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       ret_halt, ret_halt_nxt;

    ctl_t dec_ctl, ctl;
    logic dec_mc, dec_go;

    // Normal decode shared by RUN and STEP; branch > multi-cycle > load-use stall.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        dec_mc  = 1'b0;
        dec_go  = 1'b0;
        dec_ctl = CTL_GO;
        if (br_taken_ex) begin
            dec_ctl = CTL_BRANCH;
        end else if (mc_start_ex) begin
            dec_ctl = CTL_FREEZE;
            dec_mc  = 1'b1;
        end else if (hdu_stall) begin
            dec_ctl = CTL_STALL;
        end else begin
            dec_go  = 1'b1;
        end
    end

    always_comb begin
        ctl          = CTL_FREEZE;
        mc_busy      = 1'b0;
        halted       = 1'b0;
        state_nxt    = state;
        cnt_nxt      = cnt;
        ret_halt_nxt = ret_halt;

        case (state)
            S_RUN: begin
                ctl = dec_ctl;
                if (dec_mc) begin
                    state_nxt = S_MC_WAIT;
                    cnt_nxt   = MC_INIT;
                end else if (dec_go && halt_req) begin
                    state_nxt = S_HALT;
                end
            end
            S_MC_WAIT: begin
                if (cnt != 4'd0) begin
                    mc_busy = 1'b1;
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    ctl          = CTL_GO;
                    state_nxt    = (ret_halt || halt_req) ? S_HALT : S_RUN;
                    ret_halt_nxt = 1'b0;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (!halt_req) begin
                    state_nxt = S_RUN;
                end else if (step_req) begin
                    state_nxt = S_STEP;
                end
            end
            S_STEP: begin
                ctl = dec_ctl;
                // A multi-cycle op started by a step must come back to HALT once it drains.
                if (dec_mc) begin
                    state_nxt    = S_MC_WAIT;
                    cnt_nxt      = MC_INIT;
                    ret_halt_nxt = 1'b1;
                end else begin
                    state_nxt = halt_req ? S_HALT : S_RUN;
                end
            end
            default: state_nxt = S_RUN;
        endcase

        if (rst) begin
            ctl     = CTL_RESET;
            mc_busy = 1'b0;
            halted  = 1'b0;
        end
    end

    assign {pc_en, fd_en, fd_flush, dx_en, dx_flush, xm_flush} = ctl;

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state    <= S_RUN;
            cnt      <= 4'd0;
            ret_halt <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ret_halt <= ret_halt_nxt;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (MC_LATENCY 4 and 1) share directed then random
// stimulus, checked against a cycle-indexed behavioural model of the sequencing rules.
module tb_pipeline_ctrl;

    localparam int LAT0 = 4;
    localparam int LAT1 = 1;

    // Output vector bit order: pc_en fd_en fd_flush dx_en dx_flush xm_flush mc_busy halted
    localparam logic [7:0] O_RESET  = 8'b0010_1100;
    localparam logic [7:0] O_FREEZE = 8'b0000_0100;
    localparam logic [7:0] O_GO     = 8'b1101_0000;
    localparam logic [7:0] O_BRANCH = 8'b1111_1000;
    localparam logic [7:0] O_STALL  = 8'b0001_1000;
    localparam logic [7:0] B_BUSY   = 8'b0000_0010;
    localparam logic [7:0] B_HALTED = 8'b0000_0001;
    // dx_en is left open on branch/stall cycles (its flush dominates); fd_flush too on stall.
    localparam logic [7:0] C_ALL    = 8'hFF;
    localparam logic [7:0] C_BRANCH = 8'b1110_1111;
    localparam logic [7:0] C_STALL  = 8'b1100_1111;

    localparam int M_RUN = 0, M_MC = 1, M_HALT = 2, M_STEP = 3;
    localparam int K_BR = 0, K_MC = 1, K_STALL = 2, K_GO = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, hdu_stall, br_taken_ex, mc_start_ex, halt_req, step_req;
    logic [1:0] pc_en, fd_en, fd_flush, dx_en, dx_flush, xm_flush, mc_busy, halted;

    pipeline_ctrl #(.MC_LATENCY(LAT0)) dut0 (
        .clk(clk), .rst(rst), .hdu_stall(hdu_stall), .br_taken_ex(br_taken_ex),
        .mc_start_ex(mc_start_ex), .halt_req(halt_req), .step_req(step_req),
        .pc_en(pc_en[0]), .fd_en(fd_en[0]), .fd_flush(fd_flush[0]), .dx_en(dx_en[0]),
        .dx_flush(dx_flush[0]), .xm_flush(xm_flush[0]), .mc_busy(mc_busy[0]), .halted(halted[0])
    );

    pipeline_ctrl #(.MC_LATENCY(LAT1)) dut1 (
        .clk(clk), .rst(rst), .hdu_stall(hdu_stall), .br_taken_ex(br_taken_ex),
        .mc_start_ex(mc_start_ex), .halt_req(halt_req), .step_req(step_req),
        .pc_en(pc_en[1]), .fd_en(fd_en[1]), .fd_flush(fd_flush[1]), .dx_en(dx_en[1]),
        .dx_flush(dx_flush[1]), .xm_flush(xm_flush[1]), .mc_busy(mc_busy[1]), .halted(halted[1])
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int lat [2] = '{LAT0, LAT1};
    int m_mode [2];
    int m_release [2];
    bit m_ret [2];
    logic [7:0] last_obs [2];
    string out_name [8] = '{"halted", "mc_busy", "xm_flush", "dx_flush",
                            "dx_en", "fd_flush", "fd_en", "pc_en"};

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] observe(input int i);
        return {pc_en[i], fd_en[i], fd_flush[i], dx_en[i], dx_flush[i], xm_flush[i],
                mc_busy[i], halted[i]};
    endfunction

    function automatic int decode_kind();
        if (br_taken_ex) return K_BR;
        if (mc_start_ex) return K_MC;
        if (hdu_stall)   return K_STALL;
        return K_GO;
    endfunction

    // Expected outputs for this cycle, then advance the model across the coming clock edge.
    task automatic model(input int i, output logic [7:0] e, output logic [7:0] c);
        int k;
        k = decode_kind();
        c = C_ALL;
        e = O_FREEZE;
        if (rst) begin
            e = O_RESET;
            m_mode[i] = M_RUN;
            m_ret[i] = 1'b0;
        end else if (m_mode[i] == M_RUN || m_mode[i] == M_STEP) begin
            case (k)
                K_BR:    begin e = O_BRANCH; c = C_BRANCH; end
                K_MC:    e = O_FREEZE;
                K_STALL: begin e = O_STALL; c = C_STALL; end
                default: e = O_GO;
            endcase
            if (k == K_MC) begin
                m_release[i] = cyc + lat[i];
                m_ret[i] = (m_mode[i] == M_STEP);
                m_mode[i] = M_MC;
            end else if (m_mode[i] == M_STEP) begin
                m_mode[i] = halt_req ? M_HALT : M_RUN;
            end else if (k == K_GO && halt_req) begin
                m_mode[i] = M_HALT;
            end
        end else if (m_mode[i] == M_MC) begin
            if (cyc < m_release[i]) begin
                e = O_FREEZE | B_BUSY;
            end else begin
                e = O_GO;
                m_mode[i] = (m_ret[i] || halt_req) ? M_HALT : M_RUN;
                m_ret[i] = 1'b0;
            end
        end else begin
            e = O_FREEZE | B_HALTED;
            if (!halt_req) m_mode[i] = M_RUN;
            else if (step_req) m_mode[i] = M_STEP;
        end
    endtask

    task automatic cycle(input logic r, input logic h, input logic b, input logic m,
                         input logic hr, input logic s);
        logic [7:0] e, c, o;
        @(negedge clk);
        rst = r; hdu_stall = h; br_taken_ex = b; mc_start_ex = m; halt_req = hr; step_req = s;
        #1;
        for (int i = 0; i < 2; i++) begin
            model(i, e, c);
            o = observe(i);
            last_obs[i] = o;
            for (int j = 0; j < 8; j++)
                if (c[j]) check($sformatf("dut%0d.%s@%0d", i, out_name[j], cyc), o[j], e[j]);
        end
        cyc++;
    endtask

    function automatic bit is_frozen(input logic [7:0] o);
        return (o[7] == 1'b0) && (o[2] == 1'b1) && (o[0] == 1'b0);
    endfunction

    initial begin
        int frz [2];
        int steps;
        logic hl;
        rst = 1'b1; hdu_stall = 1'b0; br_taken_ex = 1'b0; mc_start_ex = 1'b0;
        halt_req = 1'b0; step_req = 1'b0;

        // Reset held three cycles, then a multi-cycle op at T
        repeat (3) cycle(1, 0, 0, 0, 0, 0);
        frz = '{0, 0};
        cycle(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) if (is_frozen(last_obs[i])) frz[i]++;
        repeat (6) begin
            cycle(0, 0, 0, 0, 0, 0);
            for (int i = 0; i < 2; i++) if (is_frozen(last_obs[i])) frz[i]++;
        end
        check("mc_freeze_len_lat4", frz[0], LAT0);
        check("mc_freeze_len_lat1", frz[1], LAT1);

        // Branch beats stall; stall alone lasts exactly its asserted cycle
        cycle(0, 1, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // Halt request behind two stall cycles, hold, resume
        cycle(0, 1, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        repeat (5) cycle(0, 0, 0, 0, 1, 0);
        check("halt_held", last_obs[0][0], 1'b1);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("resumed", last_obs[0][0], 1'b0);

        // Three single-step pulses from HALT
        cycle(0, 0, 0, 0, 1, 0);
        steps = 0;
        for (int p = 0; p < 3; p++) begin
            cycle(0, 0, 0, 0, 1, 1);
            if (last_obs[0][7] && !last_obs[0][0]) steps++;
            repeat (3) begin
                cycle(0, 0, 0, 0, 1, 0);
                if (last_obs[0][7] && !last_obs[0][0]) steps++;
            end
        end
        check("step_count", steps, 3);
        check("halted_after_steps", last_obs[0][0], 1'b1);

        // Step onto a multi-cycle op, then back to HALT
        cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 1, 0);
        repeat (6) cycle(0, 0, 0, 0, 1, 0);
        check("halted_after_step_mc", last_obs[0][0], 1'b1);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // Reset mid MC_WAIT aborts; a fresh op freezes the full latency
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        check("rst_mid_mc_busy", last_obs[0][1], 1'b0);
        cycle(0, 0, 0, 0, 0, 0);
        frz = '{0, 0};
        cycle(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) if (is_frozen(last_obs[i])) frz[i]++;
        repeat (6) begin
            cycle(0, 0, 0, 0, 0, 0);
            for (int i = 0; i < 2; i++) if (is_frozen(last_obs[i])) frz[i]++;
        end
        check("mc_refreeze_lat4", frz[0], LAT0);
        check("mc_refreeze_lat1", frz[1], LAT1);

        // Random traffic against the model
        hl = 1'b0;
        repeat (3000) begin
            if ($urandom_range(0, 7) == 0) hl = ~hl;
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0,
                  hl, $urandom_range(0, 4) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
